// File: rtl/slave_i2c_pkg.sv
// Shared types and constants for the I2C slave transmit data path.
package slave_i2c_pkg;

  // Transmit shifter states (2-bit encoding)
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ACK   = 2'd2
  } slave_tx_state_t;

  // Level driven on the serial output when no data bit is presented (released SDA)
  localparam logic SLAVE_IDLE_LVL = 1'b1;

endpackage

// File: rtl/slave_tx_hold_buf.sv
// One-word hold buffer for the slave transmit shifter: stores the next word
// while the current one is being serialised. Flush has priority over take,
// take over load. Updates on the falling edge of the SCL-derived clock.
module slave_tx_hold_buf #(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_take,
  input  logic              i_flush,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full
);

  logic [DATA_W-1:0] r_data;
  logic              r_full;

  // Buffer word and full flag
  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else if (i_flush) begin
      r_full <= 1'b0;
    end else if (i_take) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_data <= i_data;
      r_full <= 1'b1;
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule

// File: rtl/slave_piso_tx_ctrl.sv
// Parametrised slave transmit shifter for the I2C slave data path.
// Loads a DATA_W-bit word, serialises it under per-bit shift strobes, then
// releases SDA and samples the master's ACK/NACK. All state changes happen on
// the falling edge of slave_scl_sixt; every output is registered.
// Optional feature: define SLAVE_TX_PRELOAD_EN to add a one-word hold buffer
// that allows back-to-back words without returning to IDLE.
module slave_piso_tx_ctrl
  import slave_i2c_pkg::*;
#(
  parameter  int   DATA_W    = 8,
  parameter  bit   MSB_FIRST = 1'b1,
  parameter  logic IDLE_LVL  = SLAVE_IDLE_LVL,
  localparam int   CNT_W     = $clog2(DATA_W + 1)
) (
  input  logic              slave_scl_sixt,
  input  logic              slave_rst_n,
  input  logic [DATA_W-1:0] slave_data,
  input  logic              slave_load_data,
  input  logic              slave_shift_data,
  input  logic              slave_ack_sample,
  input  logic              slave_sda_in,
  output logic              slave_serial_out_data,
  output logic              slave_load_ready,
  output logic              slave_busy,
  output logic [CNT_W-1:0]  slave_bit_cnt,
  output logic              slave_byte_done,
  output logic              slave_ack_ok,
  output logic              slave_nack
);

`ifdef SLAVE_TX_PRELOAD_EN
  localparam bit PRELOAD = 1'b1;
`else
  localparam bit PRELOAD = 1'b0;
`endif

  slave_tx_state_t   r_state;
  logic [DATA_W-1:0] r_sreg;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_serial;
  logic              r_load_ready;
  logic              r_busy;
  logic              r_byte_done;
  logic              r_ack_ok;
  logic              r_nack;

  slave_tx_state_t   w_state_nxt;
  logic [DATA_W-1:0] w_sreg_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_serial_nxt;
  logic              w_ready_nxt;
  logic              w_byte_done_nxt;
  logic              w_ack_ok_nxt;
  logic              w_nack_nxt;
  logic              w_load_acc;
  logic [DATA_W-1:0] w_sreg_shifted;
  logic              w_buf_load;
  logic              w_buf_take;
  logic              w_buf_flush;
  logic              w_buf_full;
  logic              w_buf_full_nxt;
  logic [DATA_W-1:0] w_buf_data;

`ifdef SLAVE_TX_PRELOAD_EN
  slave_tx_hold_buf #(
    .DATA_W (DATA_W)
  ) u_hold_buf (
    .i_clk   (slave_scl_sixt),
    .i_rst_n (slave_rst_n),
    .i_load  (w_buf_load),
    .i_data  (slave_data),
    .i_take  (w_buf_take),
    .i_flush (w_buf_flush),
    .o_data  (w_buf_data),
    .o_full  (w_buf_full)
  );
`else
  assign w_buf_data = '0;
  assign w_buf_full = 1'b0;
`endif

  // r_load_ready already reflects state and buffer occupancy for this cycle
  assign w_load_acc = slave_load_data & r_load_ready;

  assign w_sreg_shifted = MSB_FIRST ? {r_sreg[DATA_W-2:0], 1'b0}
                                    : {1'b0, r_sreg[DATA_W-1:1]};

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt     = r_state;
    w_sreg_nxt      = r_sreg;
    w_cnt_nxt       = r_cnt;
    w_byte_done_nxt = 1'b0;
    w_ack_ok_nxt    = 1'b0;
    w_nack_nxt      = 1'b0;
    w_buf_load      = 1'b0;
    w_buf_take      = 1'b0;
    w_buf_flush     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_load_acc) begin
          w_sreg_nxt  = slave_data;
          w_cnt_nxt   = CNT_W'(DATA_W);
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_buf_load = w_load_acc;
        if (slave_shift_data) begin
          w_sreg_nxt = w_sreg_shifted;
          w_cnt_nxt  = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            w_state_nxt     = ST_ACK;
            w_byte_done_nxt = 1'b1;
          end
        end
      end
      ST_ACK: begin
        if (slave_ack_sample) begin
          if (!slave_sda_in) begin
            w_ack_ok_nxt = 1'b1;
            // A load arriving with the ACK while the buffer is empty goes
            // straight to the shifter so it is not stranded in the buffer.
            if (w_buf_full) begin
              w_buf_take  = 1'b1;
              w_sreg_nxt  = w_buf_data;
              w_cnt_nxt   = CNT_W'(DATA_W);
              w_state_nxt = ST_SHIFT;
            end else if (w_load_acc) begin
              w_sreg_nxt  = slave_data;
              w_cnt_nxt   = CNT_W'(DATA_W);
              w_state_nxt = ST_SHIFT;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_nack_nxt  = 1'b1;
            w_buf_flush = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_buf_load = w_load_acc;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    w_buf_full_nxt = w_buf_flush ? 1'b0 :
                     w_buf_take  ? 1'b0 :
                     w_buf_load  ? 1'b1 : w_buf_full;
    w_ready_nxt    = (w_state_nxt == ST_IDLE) | (PRELOAD & ~w_buf_full_nxt);
    w_serial_nxt   = (w_state_nxt == ST_SHIFT)
                   ? (MSB_FIRST ? w_sreg_nxt[DATA_W-1] : w_sreg_nxt[0])
                   : IDLE_LVL;
  end

  // State and registered outputs
  always_ff @(negedge slave_scl_sixt or negedge slave_rst_n) begin
    if (!slave_rst_n) begin
      r_state      <= ST_IDLE;
      r_sreg       <= '0;
      r_cnt        <= '0;
      r_serial     <= IDLE_LVL;
      r_load_ready <= 1'b1;
      r_busy       <= 1'b0;
      r_byte_done  <= 1'b0;
      r_ack_ok     <= 1'b0;
      r_nack       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sreg       <= w_sreg_nxt;
      r_cnt        <= w_cnt_nxt;
      r_serial     <= w_serial_nxt;
      r_load_ready <= w_ready_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_byte_done  <= w_byte_done_nxt;
      r_ack_ok     <= w_ack_ok_nxt;
      r_nack       <= w_nack_nxt;
    end
  end

  assign slave_serial_out_data = r_serial;
  assign slave_load_ready      = r_load_ready;
  assign slave_busy            = r_busy;
  assign slave_bit_cnt         = r_cnt;
  assign slave_byte_done       = r_byte_done;
  assign slave_ack_ok          = r_ack_ok;
  assign slave_nack            = r_nack;

endmodule

// File: tb/tb_slave_piso_tx_ctrl.sv
// Directed bench for slave_piso_tx_ctrl: MSB-first, LSB-first and DATA_W=2
// instances share one stimulus stream. Build with SLAVE_TX_PRELOAD_EN to
// exercise the hold buffer.
module tb_slave_piso_tx_ctrl;

  logic       clk   = 1'b1;
  logic       rst_n = 1'b1;
  logic       ld    = 1'b0;
  logic       sh    = 1'b0;
  logic       ak    = 1'b0;
  logic       sda   = 1'b1;
  logic [7:0] din   = '0;

  logic       so_m, rdy_m, busy_m, bd_m, ao_m, nk_m;
  logic [3:0] cnt_m;
  logic       so_l, rdy_l, busy_l, bd_l, ao_l, nk_l;
  logic [3:0] cnt_l;
  logic       so_2, rdy_2, busy_2, bd_2, ao_2, nk_2;
  logic [1:0] cnt_2;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] w;

  always #5 clk = ~clk;

  slave_piso_tx_ctrl #(.DATA_W(8), .MSB_FIRST(1'b1)) u_msb (
    .slave_scl_sixt(clk), .slave_rst_n(rst_n), .slave_data(din),
    .slave_load_data(ld), .slave_shift_data(sh), .slave_ack_sample(ak),
    .slave_sda_in(sda), .slave_serial_out_data(so_m), .slave_load_ready(rdy_m),
    .slave_busy(busy_m), .slave_bit_cnt(cnt_m), .slave_byte_done(bd_m),
    .slave_ack_ok(ao_m), .slave_nack(nk_m)
  );

  slave_piso_tx_ctrl #(.DATA_W(8), .MSB_FIRST(1'b0)) u_lsb (
    .slave_scl_sixt(clk), .slave_rst_n(rst_n), .slave_data(din),
    .slave_load_data(ld), .slave_shift_data(sh), .slave_ack_sample(ak),
    .slave_sda_in(sda), .slave_serial_out_data(so_l), .slave_load_ready(rdy_l),
    .slave_busy(busy_l), .slave_bit_cnt(cnt_l), .slave_byte_done(bd_l),
    .slave_ack_ok(ao_l), .slave_nack(nk_l)
  );

  slave_piso_tx_ctrl #(.DATA_W(2), .MSB_FIRST(1'b1)) u_w2 (
    .slave_scl_sixt(clk), .slave_rst_n(rst_n), .slave_data(din[1:0]),
    .slave_load_data(ld), .slave_shift_data(sh), .slave_ack_sample(ak),
    .slave_sda_in(sda), .slave_serial_out_data(so_2), .slave_load_ready(rdy_2),
    .slave_busy(busy_2), .slave_bit_cnt(cnt_2), .slave_byte_done(bd_2),
    .slave_ack_ok(ao_2), .slave_nack(nk_2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Advance past the next active (falling) edge and settle
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    // ---- reset state ----
    #1 rst_n = 1'b0;
    #1;
    chk("rst_so_m",    32'(so_m),   32'd1);
    chk("rst_cnt_m",   32'(cnt_m),  32'd0);
    chk("rst_busy_m",  32'(busy_m), 32'd0);
    chk("rst_rdy_m",   32'(rdy_m),  32'd1);
    chk("rst_pulse_m", 32'({bd_m, ao_m, nk_m}), 32'd0);
    chk("rst_so_l",    32'(so_l),   32'd1);
    chk("rst_cnt_2",   32'(cnt_2),  32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy_m", 32'(busy_m), 32'd0);

    // ---- A5 on MSB- and LSB-first instances ----
    din = 8'hA5; ld = 1'b1;
    tick();
    ld = 1'b0;
    chk("a5_busy_m", 32'(busy_m), 32'd1);
    chk("a5_cnt_m",  32'(cnt_m),  32'd8);
`ifdef SLAVE_TX_PRELOAD_EN
    chk("a5_rdy_m",  32'(rdy_m),  32'd1);
`else
    chk("a5_rdy_m",  32'(rdy_m),  32'd0);
`endif
    w = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      chk("a5_so_m",  32'(so_m),  32'(w[7-i]));
      chk("a5_so_l",  32'(so_l),  32'(w[i]));
      chk("a5_cnt_l", 32'(cnt_l), 32'(8 - i));
      sh = 1'b1;
      tick();
      sh = 1'b0;
      chk("a5_bd_m", 32'(bd_m), 32'(i == 7));
    end
    chk("a5_ack_cnt_m", 32'(cnt_m), 32'd0);
    chk("a5_ack_so_m",  32'(so_m),  32'd1);
    chk("a5_ack_so_l",  32'(so_l),  32'd1);
    chk("a5_bd_l",      32'(bd_l),  32'd1);
    chk("a5_ack_busy",  32'(busy_m), 32'd1);
    tick();
    chk("a5_bd_clr", 32'(bd_m), 32'd0);
    // shift in ACK is ignored
    sh = 1'b1;
    tick();
    sh = 1'b0;
    chk("ack_sh_cnt",  32'(cnt_m),  32'd0);
    chk("ack_sh_busy", 32'(busy_m), 32'd1);
    chk("ack_sh_bd",   32'(bd_m),   32'd0);
    // ACK from master
    ak = 1'b1; sda = 1'b0;
    tick();
    ak = 1'b0; sda = 1'b1;
    chk("ackok_m",   32'(ao_m),   32'd1);
    chk("ackok_l",   32'(ao_l),   32'd1);
    chk("ackok_nk",  32'(nk_m),   32'd0);
    chk("ackok_bsy", 32'(busy_m), 32'd0);
    chk("ackok_rdy", 32'(rdy_m),  32'd1);
    tick();
    chk("ackok_clr", 32'(ao_m), 32'd0);

    // ---- C8 distinguishes bit order, then NACK with a colliding load ----
    din = 8'hC8; ld = 1'b1;
    tick();
    ld = 1'b0;
    w = 8'hC8;
    for (int i = 0; i < 8; i++) begin
      chk("c8_so_m", 32'(so_m), 32'(w[7-i]));
      chk("c8_so_l", 32'(so_l), 32'(w[i]));
      sh = 1'b1;
      tick();
      sh = 1'b0;
    end
    ak = 1'b1; sda = 1'b1; ld = 1'b1; din = 8'h3C;
    tick();
    ak = 1'b0; ld = 1'b0;
    chk("nack_nk",   32'(nk_m),   32'd1);
    chk("nack_ao",   32'(ao_m),   32'd0);
    chk("nack_busy", 32'(busy_m), 32'd0);
    chk("nack_so",   32'(so_m),   32'd1);
    tick();
    chk("nack_clr",  32'(nk_m),   32'd0);
    chk("nack_drop", 32'(busy_m), 32'd0);
    chk("nack_cnt",  32'(cnt_m),  32'd0);

    // ---- strobes in IDLE are ignored ----
    sh = 1'b1; ak = 1'b1; sda = 1'b0;
    tick();
    sh = 1'b0; ak = 1'b0; sda = 1'b1;
    chk("idle_str_busy", 32'(busy_m), 32'd0);
    chk("idle_str_cnt",  32'(cnt_m),  32'd0);
    chk("idle_str_puls", 32'({bd_m, ao_m, nk_m}), 32'd0);
    chk("idle_str_so",   32'(so_m),   32'd1);

    // ---- load + shift on the same edge in SHIFT ----
    din = 8'hF0; ld = 1'b1;
    tick();
    ld = 1'b0;
    chk("f0_so_m", 32'(so_m), 32'd1);
    chk("f0_so_l", 32'(so_l), 32'd0);
    din = 8'h0F; ld = 1'b1; sh = 1'b1;
    tick();
    ld = 1'b0; sh = 1'b0;
    chk("ldsh_cnt",  32'(cnt_m), 32'd7);
    chk("ldsh_so_m", 32'(so_m),  32'd1);
    chk("ldsh_so_l", 32'(so_l),  32'd0);
    sh = 1'b1;
    tick();
    sh = 1'b0;
    chk("ldsh_cnt2", 32'(cnt_m), 32'd6);
    chk("ldsh_so_l2", 32'(so_l), 32'd0);

    // ---- asynchronous reset mid-word ----
    rst_n = 1'b0; #1; rst_n = 1'b1;
    din = 8'hFF; ld = 1'b1;
    tick();
    ld = 1'b0;
    sh = 1'b1;
    tick(); tick(); tick();
    sh = 1'b0;
    chk("ff_cnt5", 32'(cnt_m), 32'd5);
    chk("ff_so",   32'(so_m),  32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_m), 32'd0);
    chk("arst_cnt",  32'(cnt_m),  32'd0);
    chk("arst_so",   32'(so_m),   32'd1);
    chk("arst_puls", 32'({bd_m, ao_m, nk_m}), 32'd0);
    chk("arst_rdy",  32'(rdy_m),  32'd1);
    tick();
    chk("arst_hold", 32'(cnt_m), 32'd0);
    rst_n = 1'b1;

    // ---- DATA_W=2 boundary ----
    din = 8'h02; ld = 1'b1;
    tick();
    ld = 1'b0;
    chk("w2_so0",  32'(so_2),  32'd1);
    chk("w2_cnt2", 32'(cnt_2), 32'd2);
    sh = 1'b1;
    tick();
    chk("w2_so1",  32'(so_2),  32'd0);
    chk("w2_cnt1", 32'(cnt_2), 32'd1);
    chk("w2_bd0",  32'(bd_2),  32'd0);
    tick();
    chk("w2_bd1",  32'(bd_2),  32'd1);
    chk("w2_cnt0", 32'(cnt_2), 32'd0);
    chk("w2_soI",  32'(so_2),  32'd1);
    tick();
    sh = 1'b0;
    chk("w2_nowrap", 32'(cnt_2),  32'd0);
    chk("w2_bdclr",  32'(bd_2),   32'd0);
    chk("w2_busy",   32'(busy_2), 32'd1);
    ak = 1'b1; sda = 1'b0;
    tick();
    ak = 1'b0; sda = 1'b1;
    chk("w2_ao",    32'(ao_2),   32'd1);
    chk("w2_idle",  32'(busy_2), 32'd0);
    chk("w2_rdy",   32'(rdy_2),  32'd1);

`ifdef SLAVE_TX_PRELOAD_EN
    // ---- hold buffer: seamless second word ----
    rst_n = 1'b0; #1; rst_n = 1'b1;
    din = 8'h81; ld = 1'b1;
    tick();
    ld = 1'b0;
    chk("pl_cnt8", 32'(cnt_m), 32'd8);
    chk("pl_rdy1", 32'(rdy_m), 32'd1);
    chk("pl_so",   32'(so_m),  32'd1);
    sh = 1'b1;
    tick(); tick(); tick();
    sh = 1'b0;
    din = 8'h7E; ld = 1'b1;
    tick();
    ld = 1'b0;
    chk("pl_full_rdy", 32'(rdy_m), 32'd0);
    chk("pl_cnt5",     32'(cnt_m), 32'd5);
    sh = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    sh = 1'b0;
    chk("pl_bd",       32'(bd_m),  32'd1);
    chk("pl_ack_rdy",  32'(rdy_m), 32'd0);
    ak = 1'b1; sda = 1'b0;
    tick();
    ak = 1'b0; sda = 1'b1;
    chk("pl_ao",    32'(ao_m),   32'd1);
    chk("pl_busy",  32'(busy_m), 32'd1);
    chk("pl_cnt8b", 32'(cnt_m),  32'd8);
    chk("pl_rdy2",  32'(rdy_m),  32'd1);
    w = 8'h7E;
    for (int i = 0; i < 8; i++) begin
      chk("pl_so_m", 32'(so_m), 32'(w[7-i]));
      sh = 1'b1;
      tick();
      sh = 1'b0;
    end
    chk("pl_bd2", 32'(bd_m), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
